reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the shared register.
REQ-002 Parameter PORTS, default 4: number of write requesters (2..8).
REQ-003 Parameter LOCK_TIMEOUT, default 16: idle cycles after which a held lock auto-releases (1..255).
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 wr_valid  in  PORTS  per-requester write request.
REQ-008 wr_lock  in  PORTS  per-requester lock request; sampled only with wr_valid.
REQ-009 wr_data  in  PORTS*DATA_WIDTH  write data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 wr_ready  out  PORTS  one-hot grant; the write is accepted when wr_valid[i] and wr_ready[i] are both high.
REQ-011 dout  out  DATA_WIDTH  shared register value.
REQ-012 dout_vld  out  1  high once any write has been accepted since reset.
REQ-013 upd  out  1  one-cycle pulse in the cycle after an accepted write.
REQ-014 last_src  out  3  index of the requester of the last accepted write.
REQ-015 locked  out  1  high while the FSM is in LOCKED.
REQ-016 lock_owner  out  3  owner index; valid while locked is high.

Function
REQ-017 wr_ready is combinational from wr_valid and state, and has at most one bit set.
REQ-018 wr_ready[i] is never high when wr_valid[i] is low.
REQ-019 FSM states are IDLE and LOCKED.
REQ-020 IDLE arbitration: round-robin.
  - Search starts at pointer ptr, then ptr+1, ... mod PORTS.
  - The first requester with wr_valid high is granted.
REQ-021 On an accepted write from i, ptr becomes (i+1) mod PORTS at the next edge; with no accepted write, ptr holds.
REQ-022 On an accepted write from i, at the next edge:
  - dout = wr_data[i], last_src = i, dout_vld = 1.
  - upd = 1 for exactly that one cycle.
  - Latency from acceptance to new dout is 1 cycle.
REQ-023 IDLE -> LOCKED when the accepted write has wr_lock[i] = 1; lock_owner = i.
REQ-024 In LOCKED, only lock_owner can be granted: it is granted whenever its wr_valid is high, and all other requesters stall with wr_ready = 0.
REQ-025 LOCKED -> IDLE on an accepted owner write with wr_lock = 0; the data of that write is still written.
REQ-026 An accepted owner write with wr_lock = 1 keeps the FSM in LOCKED.
REQ-027 Idle counter:
  - Counts cycles in LOCKED without an accepted owner write.
  - Clears on an accepted owner write.
  - When it reaches LOCK_TIMEOUT, the FSM returns to IDLE at that edge without writing dout, and the counter clears.
REQ-028 Timeout and an owner write in the same cycle: the write wins; the write is performed, the counter clears, and the next state follows REQ-025/REQ-026.
REQ-029 While LOCKED, ptr holds; on leaving LOCKED, arbitration resumes from ptr = (lock_owner+1) mod PORTS.
REQ-030 When all wr_valid are low, no grant is issued and no state other than the idle counter changes.

Reset
REQ-031 When rst is high at a clock edge, the block resets:
  - dout = 0, dout_vld = 0, upd = 0, last_src = 0.
  - ptr = 0, state = IDLE, locked = 0, lock_owner = 0, idle counter = 0.
REQ-032 During reset, wr_ready = 0.
REQ-033 rst during LOCKED or during a write drops the lock and discards that write; dout is 0 in the following cycle.
REQ-034 The first grant after reset release goes to the lowest-indexed valid requester.

Verification
REQ-035 Round-robin, all four ports valid (data 0x10..0x13) for 4 cycles after reset:
  - Grants are 0,1,2,3.
  - dout sequence is 0x10, 0x11, 0x12, 0x13, each one cycle after its grant, with upd high each cycle.
REQ-036 Fairness, ports 1 and 3 continuously valid: grants alternate 1,3,1,3 and port 1 is never granted twice in a row.
REQ-037 Lock handoff:
  - Stimulus: port 2 writes 0xAA with lock = 1; ports 0 and 1 stay valid.
  - Ports 0 and 1 stall (wr_ready = 0) until port 2 writes 0xBB with lock = 0.
  - Next grant goes to port 3 if valid, otherwise to port 0.
REQ-038 Lock timeout, LOCK_TIMEOUT = 16:
  - Stimulus: port 1 locks, then goes idle.
  - locked falls exactly 16 cycles after the lock write, and dout is unchanged.
  - Port 0 is granted in the cycle after that.
REQ-039 Timeout collision: owner writes 0x55 with lock = 1 in the cycle the counter reaches 16 -> dout = 0x55, locked stays 1, and the counter is 0.
REQ-040 Reset mid-lock: rst is asserted for 1 cycle while port 3 holds the lock and writes 0x77 -> dout = 0, dout_vld = 0, locked = 0, and port 0 wins the next grant.

Source files
------------

// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - round-robin shared-register write arbiter with owner lock and idle timeout
module reg_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int PORTS        = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              wr_valid,
    input  logic [PORTS-1:0]              wr_lock,
    input  logic [PORTS*DATA_WIDTH-1:0]   wr_data,
    output logic [PORTS-1:0]              wr_ready,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_vld,
    output logic                          upd,
    output logic [2:0]                    last_src,
    output logic                          locked,
    output logic [2:0]                    lock_owner
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state, state_next;
    logic [2:0]              ptr;
    logic [7:0]              idle_cnt;
    logic [7:0]              valid_pad, lock_pad, grant_pad;
    logic                    accept, acc_lock, timeout;
    logic [2:0]              gidx;
    logic [3:0]              sum;
    logic [DATA_WIDTH-1:0]   acc_data;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'(PORTS - 1)) ? 3'd0 : i + 3'd1;
    endfunction

    // Grant selection: walking downward from ptr+PORTS-1 to ptr leaves the
    // first valid requester at or after ptr as the final winner.
    always_comb begin
        valid_pad = '0;
        lock_pad  = '0;
        valid_pad[PORTS-1:0] = wr_valid;
        lock_pad[PORTS-1:0]  = wr_lock;
        accept = 1'b0;
        gidx   = '0;
        sum    = '0;
        if (state == LOCKED) begin
            accept = valid_pad[lock_owner];
            gidx   = lock_owner;
        end else begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                sum = {1'b0, ptr} + 4'(k);
                if (sum >= 4'(PORTS))
                    sum = sum - 4'(PORTS);
                if (valid_pad[sum[2:0]]) begin
                    accept = 1'b1;
                    gidx   = sum[2:0];
                end
            end
        end
        if (rst)
            accept = 1'b0;
        grant_pad = '0;
        if (accept)
            grant_pad[gidx] = 1'b1;
        acc_lock = lock_pad[gidx];
        acc_data = '0;
        for (int i = 0; i < PORTS; i++)
            if (grant_pad[i])
                acc_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wr_ready = grant_pad[PORTS-1:0];
    assign locked   = (state == LOCKED);
    // An owner write in the timeout cycle takes priority over the timeout.
    assign timeout  = (state == LOCKED) && !accept && (idle_cnt == 8'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (accept && acc_lock)
                state_next = LOCKED;
        end else if (accept) begin
            if (!acc_lock)
                state_next = IDLE;
        end else if (timeout) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idle_cnt   <= '0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            upd        <= 1'b0;
            last_src   <= '0;
            lock_owner <= '0;
        end else begin
            state <= state_next;
            upd   <= accept;
            if (accept) begin
                dout     <= acc_data;
                dout_vld <= 1'b1;
                last_src <= gidx;
            end
            if (state == IDLE) begin
                idle_cnt <= '0;
                if (accept) begin
                    ptr <= next_idx(gidx);
                    if (acc_lock)
                        lock_owner <= gidx;
                end
            end else begin
                if (accept || timeout)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 8'd1;
                if (state_next == IDLE)
                    ptr <= next_idx(lock_owner);
            end
        end
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - directed and randomized bench for reg_arbiter against a behavioural model
module tb_reg_arbiter;
    localparam int P  = 4;
    localparam int DW = 8;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [P-1:0]  valid = '0;
    logic [P-1:0]  lock = '0;
    logic [P*DW-1:0] data = '0;
    logic [P-1:0]  wr_ready;
    logic [DW-1:0] dout;
    logic          dout_vld, upd, locked;
    logic [2:0]    last_src, lock_owner;

    reg_arbiter #(.DATA_WIDTH(DW), .PORTS(P), .LOCK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .wr_valid(valid), .wr_lock(lock), .wr_data(data),
        .wr_ready(wr_ready), .dout(dout), .dout_vld(dout_vld), .upd(upd),
        .last_src(last_src), .locked(locked), .lock_owner(lock_owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit         m_locked, m_vld, m_upd;
    int         m_owner, m_ptr, m_cnt, m_last;
    logic [7:0] m_dout;
    logic [P-1:0] obs_ready, exp_ready;

    function automatic int model_grant();
        if (rst) return -1;
        if (m_locked) return valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < P; k++)
            if (valid[(m_ptr + k) % P]) return (m_ptr + k) % P;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_locked = 0; m_vld = 0; m_upd = 0; m_owner = 0; m_ptr = 0;
            m_cnt = 0; m_last = 0; m_dout = 0;
            return;
        end
        m_upd = (g >= 0);
        if (g >= 0) begin
            m_dout = data[g*DW +: DW];
            m_last = g;
            m_vld  = 1;
        end
        if (!m_locked) begin
            if (g >= 0) begin
                m_ptr = (g + 1) % P;
                if (lock[g]) begin m_locked = 1; m_owner = g; m_cnt = 0; end
            end
        end else if (g >= 0) begin
            m_cnt = 0;
            if (!lock[g]) begin m_locked = 0; m_ptr = (m_owner + 1) % P; end
        end else begin
            m_cnt++;
            if (m_cnt == T) begin m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % P; end
        end
    endtask

    // Inputs are set at the falling edge; returns at the next falling edge.
    task automatic cycle();
        int g;
        #1;
        obs_ready = wr_ready;
        g = model_grant();
        exp_ready = (g < 0) ? '0 : P'(1 << g);
        @(posedge clk);
        model_update(g);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; valid = '0; lock = '0;
        cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; valid = '1; data = $urandom;
        cycle();
        checks++; if (obs_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0", obs_ready); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++; if ({dout_vld, upd, locked} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {dout_vld, upd, locked}); end
        checks++; if ({last_src, lock_owner} !== 6'd0) begin errors++; $display("FAIL reset_idx got %h exp 0", {last_src, lock_owner}); end
        rst = 0; valid = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        valid = 4'hF; lock = '0; data = 32'h13121110;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++; if (obs_ready !== P'(1 << k)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, obs_ready, P'(1 << k)); end
            checks++; if (dout !== 8'(8'h10 + k) || upd !== 1'b1) begin errors++; $display("FAIL rr_dout%0d got %h/%b exp %h/1", k, dout, upd, 8'(8'h10 + k)); end
        end
        valid = '0;
        cycle();
        checks++; if (upd !== 1'b0 || dout !== 8'h13) begin errors++; $display("FAIL rr_quiet got %b/%h exp 0/13", upd, dout); end
    endtask

    task automatic test_fairness();
        do_reset();
        valid = 4'b1010; data = $urandom;
        for (int k = 0; k < 6; k++) begin
            cycle();
            checks++; if (obs_ready !== ((k % 2) ? 4'b1000 : 4'b0010)) begin errors++; $display("FAIL fair%0d got %b", k, obs_ready); end
        end
    endtask

    task automatic test_lock_handoff();
        for (int v = 0; v < 2; v++) begin
            int stalls;
            do_reset();
            valid = 4'b0100; lock = 4'b0100; data = 32'h00AA0000;
            cycle();
            checks++; if (locked !== 1'b1 || lock_owner !== 3'd2 || dout !== 8'hAA) begin errors++; $display("FAIL lock_take got %b/%0d/%h exp 1/2/aa", locked, lock_owner, dout); end
            valid = 4'b0011; lock = '0; stalls = 0;
            repeat (3) begin cycle(); if (obs_ready !== '0) stalls++; end
            checks++; if (stalls !== 0 || dout !== 8'hAA) begin errors++; $display("FAIL lock_stall got %0d/%h exp 0/aa", stalls, dout); end
            valid = 4'b0111; data = 32'h00BB0000;
            cycle();
            checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL lock_owner_wr got %b exp 0100", obs_ready); end
            checks++; if (locked !== 1'b0 || dout !== 8'hBB) begin errors++; $display("FAIL lock_release got %b/%h exp 0/bb", locked, dout); end
            valid = v ? 4'b1011 : 4'b0011;
            cycle();
            checks++; if (obs_ready !== (v ? 4'b1000 : 4'b0001)) begin errors++; $display("FAIL lock_next%0d got %b", v, obs_ready); end
        end
        valid = '0;
    endtask

    task automatic test_lock_timeout();
        int n, stalls;
        do_reset();
        valid = 4'b0010; lock = 4'b0010; data = 32'h00003C00;
        cycle();
        valid = 4'b0001; lock = '0; data = 32'h000000EE; n = 0; stalls = 0;
        while (locked === 1'b1 && n < 40) begin
            cycle(); n++;
            if (obs_ready !== '0) stalls++;
        end
        checks++; if (n !== T) begin errors++; $display("FAIL timeout_len got %0d exp %0d", n, T); end
        checks++; if (stalls !== 0 || dout !== 8'h3C || upd !== 1'b0) begin errors++; $display("FAIL timeout_dout got %0d/%h/%b exp 0/3c/0", stalls, dout, upd); end
        cycle();
        checks++; if (obs_ready !== 4'b0001 || dout !== 8'hEE) begin errors++; $display("FAIL timeout_next got %b/%h exp 0001/ee", obs_ready, dout); end
        valid = '0;
    endtask

    task automatic test_timeout_collision();
        int n;
        do_reset();
        valid = 4'b0010; lock = 4'b0010; data = 32'h00001100;
        cycle();
        valid = '0;
        repeat (T - 1) cycle();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL coll_pre got %b exp 1", locked); end
        valid = 4'b0010; lock = 4'b0010; data = 32'h00005500;
        cycle();
        checks++; if (obs_ready !== 4'b0010 || dout !== 8'h55 || locked !== 1'b1) begin errors++; $display("FAIL coll_write got %b/%h/%b exp 0010/55/1", obs_ready, dout, locked); end
        valid = '0; n = 0;
        while (locked === 1'b1 && n < 40) begin cycle(); n++; end
        checks++; if (n !== T) begin errors++; $display("FAIL coll_counter got %0d exp %0d", n, T); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        valid = 4'b1000; lock = 4'b1000; data = 32'h33000000;
        cycle();
        checks++; if (locked !== 1'b1 || lock_owner !== 3'd3) begin errors++; $display("FAIL rml_lock got %b/%0d exp 1/3", locked, lock_owner); end
        rst = 1; valid = 4'b1001; data = 32'h77000044;
        cycle();
        checks++; if (obs_ready !== '0) begin errors++; $display("FAIL rml_ready got %b exp 0", obs_ready); end
        checks++; if (dout !== 8'h00 || dout_vld !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rml_state got %h/%b/%b exp 00/0/0", dout, dout_vld, locked); end
        rst = 0;
        cycle();
        checks++; if (obs_ready !== 4'b0001 || dout !== 8'h44) begin errors++; $display("FAIL rml_next got %b/%h exp 0001/44", obs_ready, dout); end
        valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 79) == 0);
            valid = ((c % 64) > 40) ? '0 : P'($urandom);
            lock  = P'($urandom) & P'($urandom);
            data  = $urandom;
            cycle();
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, obs_ready, exp_ready); end
            checks++; if (dout !== m_dout || dout_vld !== m_vld || upd !== m_upd) begin errors++; $display("FAIL rand_dout c%0d got %h/%b/%b exp %h/%b/%b", c, dout, dout_vld, upd, m_dout, m_vld, m_upd); end
            checks++; if (last_src !== 3'(m_last) || locked !== m_locked) begin errors++; $display("FAIL rand_src c%0d got %0d/%b exp %0d/%b", c, last_src, locked, m_last, m_locked); end
            if (m_locked) begin
                checks++; if (lock_owner !== 3'(m_owner)) begin errors++; $display("FAIL rand_owner c%0d got %0d exp %0d", c, lock_owner, m_owner); end
            end
        end
        rst = 0; valid = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_fairness();
        test_lock_handoff();
        test_lock_timeout();
        test_timeout_collision();
        test_reset_mid_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
